// File: rtl/fc_mac_layer.sv
// Dense layer: captures one feature vector, then streams OUT_COUNT saturated dot products
// (optionally ReLU-clamped) using an external 1-cycle-latency weight memory.
module fc_mac_layer #(
   parameter  int IN_COUNT  = 16,
   parameter  int OUT_COUNT = 10,
   parameter  int DATA_W    = 32,
   parameter  int FRAC_W    = 15,
   parameter  int RELU      = 1,
   localparam int AW        = (IN_COUNT * OUT_COUNT > 1) ? $clog2(IN_COUNT * OUT_COUNT) : 1,
   localparam int IW        = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IN_COUNT*DATA_W-1:0]   in_data,
   output logic                         w_en,
   output logic [AW-1:0]                w_addr,
   input  logic [DATA_W-1:0]            w_rdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [IW-1:0]                out_index,
   output logic                         out_last
);

   localparam int KW    = $clog2(IN_COUNT + 1);
   localparam int XW    = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
   localparam int ACC_W = 2 * DATA_W + $clog2(IN_COUNT);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2} state_t;

   state_t                     state_r, state_s;
   logic signed [DATA_W-1:0]   x_r [IN_COUNT];
   logic [KW-1:0]              k_r;
   logic [IW-1:0]              n_r;
   logic signed [ACC_W-1:0]    acc_r, sum_s, shift_s;
   logic signed [2*DATA_W-1:0] prod_s;
   logic signed [DATA_W-1:0]   xsel_s, sat_s, res_s;
   logic [XW-1:0]              idx_s;
   logic                       k_end_s, last_n_s;
   logic                       in_ready_r, w_en_r, out_valid_r, out_last_r;
   logic [AW-1:0]              w_addr_r;
   logic [DATA_W-1:0]          out_data_r;
   logic [IW-1:0]              out_index_r;

   assign in_ready  = in_ready_r;
   assign w_en      = w_en_r;
   assign w_addr    = w_addr_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_index = out_index_r;
   assign out_last  = out_last_r;

   // MAC datapath: weight read at step k-1 returns now and pairs with feature k-1
   always_comb begin
      k_end_s  = (k_r == KW'(IN_COUNT));
      last_n_s = (n_r == IW'(OUT_COUNT - 1));
      idx_s    = XW'(k_r - KW'(1));
      if (k_r != {KW{1'b0}}) begin
         xsel_s = x_r[idx_s];
      end else begin
         xsel_s = {DATA_W{1'b0}};
      end
      prod_s  = (2*DATA_W)'(xsel_s) * (2*DATA_W)'($signed(w_rdata));
      sum_s   = acc_r + ACC_W'(prod_s);
      shift_s = sum_s >>> FRAC_W;
      if (shift_s > SAT_MAX) begin
         sat_s = SAT_MAX[DATA_W-1:0];
      end else if (shift_s < SAT_MIN) begin
         sat_s = SAT_MIN[DATA_W-1:0];
      end else begin
         sat_s = shift_s[DATA_W-1:0];
      end
      if ((RELU != 0) && sat_s[DATA_W-1]) begin
         res_s = {DATA_W{1'b0}};
      end else begin
         res_s = sat_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE:  if (in_valid) state_s = S_MAC; else state_s = S_IDLE;
         S_MAC:   if (k_end_s) state_s = S_OUT; else state_s = S_MAC;
         S_OUT: begin
            if (out_ready) begin
               if (last_n_s) state_s = S_IDLE; else state_s = S_MAC;
            end else begin
               state_s = S_OUT;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // State, counters, accumulator and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         k_r         <= {KW{1'b0}};
         n_r         <= {IW{1'b0}};
         acc_r       <= {ACC_W{1'b0}};
         in_ready_r  <= 1'b1;
         w_en_r      <= 1'b0;
         w_addr_r    <= {AW{1'b0}};
         out_valid_r <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_index_r <= {IW{1'b0}};
         out_last_r  <= 1'b0;
         for (int i = 0; i < IN_COUNT; i++) x_r[i] <= {DATA_W{1'b0}};
      end else begin
         state_r <= state_s;
         case (state_r)
            S_IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < IN_COUNT; i++) x_r[i] <= in_data[i*DATA_W +: DATA_W];
                  k_r        <= {KW{1'b0}};
                  n_r        <= {IW{1'b0}};
                  acc_r      <= {ACC_W{1'b0}};
                  in_ready_r <= 1'b0;
                  w_en_r     <= 1'b1;
                  w_addr_r   <= {AW{1'b0}};
               end
            end
            S_MAC: begin
               if (k_r != {KW{1'b0}}) acc_r <= sum_s;
               if (k_end_s) begin
                  out_valid_r <= 1'b1;
                  out_data_r  <= res_s;
                  out_index_r <= n_r;
                  out_last_r  <= last_n_s;
               end else begin
                  k_r <= k_r + KW'(1);
               end
               // The address register already holds n*IN_COUNT+k; it steps only while reads remain
               if (k_r == KW'(IN_COUNT - 1)) begin
                  w_en_r <= 1'b0;
               end else if (!k_end_s) begin
                  w_addr_r <= w_addr_r + AW'(1);
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  if (last_n_s) begin
                     in_ready_r <= 1'b1;
                  end else begin
                     n_r      <= n_r + IW'(1);
                     k_r      <= {KW{1'b0}};
                     acc_r    <= {ACC_W{1'b0}};
                     w_en_r   <= 1'b1;
                     w_addr_r <= w_addr_r + AW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_mac_layer.sv
// Randomized self-checking bench: two instances (ReLU on/off) share stimulus and a weight table;
// results are checked against a plain-arithmetic dot-product model.
module tb_fc_mac_layer;

   localparam int NI = 4;
   localparam int NO = 2;

   logic              clk, rst_n, in_valid, out_ready;
   logic [NI*32-1:0]  in_data;
   logic [31:0]       rd0, rd1;
   logic              in_ready0, in_ready1, w_en0, w_en1, out_valid0, out_valid1, out_last0, out_last1;
   logic [2:0]        w_addr0, w_addr1;
   logic [31:0]       out_data0, out_data1;
   logic [0:0]        out_index0, out_index1;

   logic [31:0]       x_m [NI];
   logic [31:0]       rom [NI*NO];
   int                n_cmp, n_bad;

   fc_mac_layer #(.IN_COUNT(NI), .OUT_COUNT(NO), .DATA_W(32), .FRAC_W(15), .RELU(1)) u_relu (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
      .w_en(w_en0), .w_addr(w_addr0), .w_rdata(rd0), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_index(out_index0), .out_last(out_last0));

   fc_mac_layer #(.IN_COUNT(NI), .OUT_COUNT(NO), .DATA_W(32), .FRAC_W(15), .RELU(0)) u_lin (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .w_en(w_en1), .w_addr(w_addr1), .w_rdata(rd1), .out_valid(out_valid1), .out_ready(out_ready),
      .out_data(out_data1), .out_index(out_index1), .out_last(out_last1));

   always #5 clk = ~clk;

   // Synchronous weight ROM; garbage when not read so stray use of w_rdata shows up
   always @(posedge clk) begin
      rd0 <= w_en0 ? rom[w_addr0] : $urandom;
      rd1 <= w_en1 ? rom[w_addr1] : $urandom;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_out(input int n, input bit relu);
      logic signed [70:0] acc, r;
      logic [31:0] y;
      acc = 71'sd0;
      for (int k = 0; k < NI; k++) acc = acc + $signed(x_m[k]) * $signed(rom[n*NI+k]);
      r = acc >>> 15;
      if (r > 71'sd2147483647)        y = 32'h7FFF_FFFF;
      else if (r < -71'sd2147483648)  y = 32'h8000_0000;
      else                            y = r[31:0];
      if (relu && y[31]) y = 32'h0;
      return y;
   endfunction

   task automatic set_all(input logic [31:0] xv, input logic [31:0] w0, input logic [31:0] w1);
      for (int k = 0; k < NI; k++) begin
         x_m[k]      = xv;
         rom[k]      = w0;
         rom[NI + k] = w1;
      end
   endtask

   function automatic logic [31:0] rnd_word();
      if ($urandom_range(0, 1) == 0) return $urandom;
      return 32'($urandom_range(0, 131071)) - 32'd65536;
   endfunction

   task automatic pack();
      for (int k = 0; k < NI; k++) in_data[k*32 +: 32] = x_m[k];
   endtask

   // mode 0: ready always 1, 1: random ready, 2: stall 5 cycles per result; noisy keeps in_valid high
   task automatic run_vec(input int mode, input bit noisy);
      int cyc, n, hs_cyc, stall;
      bit seen;
      chk("in_ready_idle", 64'(in_ready0), 64'd1);
      pack();
      in_valid = 1'b1;
      cyc = 0; n = 0; hs_cyc = 0; stall = 0; seen = 1'b0;
      while (n < NO && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (out_valid0) begin
            if (!seen) chk("latency", 64'(cyc - hs_cyc), 64'(NI + 2));
            seen = 1'b1;
            chk("data_relu", 64'(out_data0), 64'(ref_out(n, 1'b1)));
            chk("data_lin",  64'(out_data1), 64'(ref_out(n, 1'b0)));
            chk("index",     64'(out_index0), 64'(n));
            chk("last",      64'(out_last0), 64'(n == NO - 1));
            chk("valid_lin", 64'(out_valid1), 64'd1);
            chk("w_en_out",  64'(w_en0), 64'd0);
            chk("busy_out",  64'(in_ready0), 64'd0);
            case (mode)
               0:       out_ready = 1'b1;
               1:       out_ready = 1'($urandom_range(0, 1));
               default: out_ready = (stall >= 5);
            endcase
            stall++;
            if (out_ready) begin
               n++; hs_cyc = cyc; seen = 1'b0; stall = 0;
            end
         end else begin
            chk("busy_mac", 64'(in_ready0), 64'd0);
            out_ready = 1'($urandom_range(0, 1));
         end
         if (noisy && !(n == NO)) begin
            in_valid = 1'b1;
            for (int k = 0; k < NI; k++) in_data[k*32 +: 32] = $urandom;
         end else begin
            in_valid = 1'b0;
         end
      end
      if (n < NO) chk("timeout", 64'(n), 64'(NO));
      @(negedge clk);
      chk("in_ready_back", 64'(in_ready0), 64'd1);
      chk("valid_drop", 64'(out_valid0), 64'd0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_in_ready",  64'(in_ready0), 64'd1);
      chk("rst_out_valid", 64'(out_valid0), 64'd0);
      chk("rst_out_data",  64'(out_data1), 64'd0);
      chk("rst_out_index", 64'(out_index0), 64'd0);
      chk("rst_out_last",  64'(out_last0), 64'd0);
      chk("rst_w_en",      64'(w_en0), 64'd0);
      chk("rst_w_addr",    64'(w_addr0), 64'd0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      set_all(32'd0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      chk_reset_vals();
      rst_n = 1'b1;
      @(negedge clk);

      set_all(32'd32768, 32'd16384, 32'd16384);              run_vec(0, 1'b0);
      set_all(32'd32768, 32'hFFFF_C000, 32'd16384);          run_vec(1, 1'b0);
      set_all(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);  run_vec(0, 1'b0);
      set_all(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000);  run_vec(1, 1'b0);
      set_all(32'd32768, 32'd16384, 32'hFFFF_C000);          run_vec(2, 1'b0);

      // Reset mid-MAC, then a clean vector
      set_all(32'd32768, 32'd16384, 32'd16384);
      pack();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(0, 1'b0);

      // Busy-time input noise, then random traffic
      for (int k = 0; k < NI; k++) x_m[k] = rnd_word();
      for (int i = 0; i < NI * NO; i++) rom[i] = rnd_word();
      run_vec(1, 1'b1);
      for (int t = 0; t < 20; t++) begin
         for (int k = 0; k < NI; k++) x_m[k] = rnd_word();
         for (int i = 0; i < NI * NO; i++) rom[i] = rnd_word();
         run_vec(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
